regfile_read_arbiter: RTL and testbench

//  Shares one 32-bit register-file read port among NUM_REQ requesters, e.g. decode rs1/rs2, debug, CSR.
//  The read port is the array of 32:1 bit-select muxes, one per data bit, all driven by a common 5-bit select.

---
 rtl/regfile_read_arbiter.sv | 74 +++++++
 tb/tb_regfile_read_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/regfile_read_arbiter.sv
// rtl/regfile_read_arbiter.sv - round-robin arbiter sharing one register-file read port
// Registered grant and mux select, read data captured into a response register one cycle later.
module regfile_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic                      stall,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rd_sel,
  input  logic [DATA_W-1:0]         rd_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [NUM_REQ-1:0] eligible;
  logic [ADDR_W-1:0]  rd_sel_q, rd_sel_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   win;
  logic               found;

  always_comb begin
    // The current grantee is masked so a held request cannot win twice in a row.
    eligible   = req & ~gnt_q;
    found      = 1'b0;
    win        = ptr_q;
    gnt_d      = '0;
    rd_sel_d   = rd_sel_q;
    ptr_d      = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && eligible[(int'(ptr_q) + k) % NUM_REQ]) begin
        found = 1'b1;
        win   = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
    if (!stall && found) begin
      gnt_d    = NUM_REQ'(1) << win;
      rd_sel_d = addr[win*ADDR_W +: ADDR_W];
      ptr_d    = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
    end
    rsp_data_d = (|gnt_q) ? rd_data : rsp_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rd_sel_q    <= '0;
      ptr_q       <= '0;
    end else begin
      gnt_q       <= gnt_d;
      rsp_valid_q <= gnt_q;
      rsp_data_q  <= rsp_data_d;
      rd_sel_q    <= rd_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign rd_sel    = rd_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// tb/tb_regfile_read_arbiter.sv - directed self-checking bench for regfile_read_arbiter
// The bench owns a small register-file array that drives rd_data from rd_sel.
module tb_regfile_read_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [19:0] addr;
  logic        stall;
  logic [3:0]  gnt;
  logic [4:0]  rd_sel;
  logic [31:0] rd_data;
  logic [3:0]  rsp_valid;
  logic [31:0] rsp_data;

  logic [31:0] regs [32];
  int checks = 0;
  int errors = 0;

  regfile_read_arbiter #(.NUM_REQ(4), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .stall(stall),
    .gnt(gnt), .rd_sel(rd_sel), .rd_data(rd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;
  assign rd_data = regs[rd_sel];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; req = 4'b1111;
    addr = {5'd4, 5'd3, 5'd2, 5'd1};
    tick(); tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b want 0000", gnt); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid got %b want 0000", rsp_valid); end
    checks++; if (rd_sel !== 5'd0) begin errors++; $display("FAIL reset_rd_sel got %0d want 0", rd_sel); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
    rst = 1'b0;
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL reset_first_gnt got %b want 0001", gnt); end
    req = 4'b0000;
    tick();
    checks++; if (rsp_data !== 32'h1111_0001) begin errors++; $display("FAIL reset_first_rsp got %h want 11110001", rsp_data); end
    tick();
  endtask

  task automatic test_single_read();
    req = 4'b0001; addr = {5'd0, 5'd0, 5'd0, 5'd7};
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt got %b want 0001", gnt); end
    checks++; if (rd_sel !== 5'd7) begin errors++; $display("FAIL single_rd_sel got %0d want 7", rd_sel); end
    req = 4'b0000;
    tick();
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid got %b want 0001", rsp_valid); end
    checks++; if (rsp_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rsp_data got %h want deadbeef", rsp_data); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_no_regrant got %b want 0000", gnt); end
    tick();
  endtask

  task automatic test_contention();
    logic [3:0]  exp_g [5];
    logic [3:0]  exp_v [5];
    logic [31:0] exp_d [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    exp_v = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_d = '{32'h1111_0001, 32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
    rst = 1'b1; req = 4'b0000; tick(); rst = 1'b0;
    req = 4'b1111; addr = {5'd4, 5'd3, 5'd2, 5'd1};
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (gnt !== exp_g[c]) begin errors++; $display("FAIL contention_gnt c%0d got %b want %b", c, gnt, exp_g[c]); end
      checks++; if (rsp_valid !== exp_v[c]) begin errors++; $display("FAIL contention_rsp_valid c%0d got %b want %b", c, rsp_valid, exp_v[c]); end
      if (c > 0) begin
        checks++; if (rsp_data !== exp_d[c]) begin errors++; $display("FAIL contention_rsp_data c%0d got %h want %h", c, rsp_data, exp_d[c]); end
      end
      req = req & ~gnt;
    end
  endtask

  task automatic test_rr_wrap();
    req = 4'b0010; addr = {5'd4, 5'd3, 5'd2, 5'd1};
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL wrap_gnt1 got %b want 0010", gnt); end
    req = 4'b0011;
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wrap_gnt0 got %b want 0001", gnt); end
    req = 4'b0010;
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL wrap_gnt1b got %b want 0010", gnt); end
    checks++; if (rsp_data !== 32'h1111_0001) begin errors++; $display("FAIL wrap_rsp0 got %h want 11110001", rsp_data); end
    req = 4'b0000;
    tick();
    req = 4'b0101;
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL wrap_ptr2 got %b want 0100", gnt); end
    req = 4'b0001;
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wrap_after_ptr got %b want 0001", gnt); end
    req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_stall();
    req = 4'b1000; addr = {5'd4, 5'd3, 5'd2, 5'd1};
    tick();
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL stall_pre_gnt got %b want 1000", gnt); end
    req = 4'b0100; stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL stall_gnt c%0d got %b want 0000", c, gnt); end
      checks++; if (rd_sel !== 5'd4) begin errors++; $display("FAIL stall_rd_sel c%0d got %0d want 4", c, rd_sel); end
      if (c == 0) begin
        checks++; if (rsp_valid !== 4'b1000) begin errors++; $display("FAIL stall_inflight_valid got %b want 1000", rsp_valid); end
        checks++; if (rsp_data !== 32'h4444_0004) begin errors++; $display("FAIL stall_inflight_data got %h want 44440004", rsp_data); end
      end
    end
    stall = 1'b0;
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL stall_release_gnt got %b want 0100", gnt); end
    checks++; if (rd_sel !== 5'd3) begin errors++; $display("FAIL stall_release_rd_sel got %0d want 3", rd_sel); end
    req = 4'b0000;
    tick();
    checks++; if (rsp_data !== 32'h3333_0003) begin errors++; $display("FAIL stall_release_rsp got %h want 33330003", rsp_data); end
    tick();
  endtask

  task automatic test_reset_mid();
    req = 4'b0010;
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL midrst_gnt got %b want 0010", gnt); end
    rst = 1'b1; req = 4'b0000;
    tick();
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL midrst_rsp_valid got %b want 0000", rsp_valid); end
    rst = 1'b0;
    tick();
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL midrst_no_late_rsp got %b want 0000", rsp_valid); end
    req = 4'b1111;
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL midrst_ptr0 got %b want 0001", gnt); end
    req = 4'b0000;
    tick(); tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'hA5A5_0000 | i;
    regs[0] = 32'h0;
    regs[1] = 32'h1111_0001;
    regs[2] = 32'h2222_0002;
    regs[3] = 32'h3333_0003;
    regs[4] = 32'h4444_0004;
    regs[7] = 32'hDEAD_BEEF;
    rst = 1'b1; req = '0; addr = '0; stall = 1'b0;
    test_reset();
    test_single_read();
    test_contention();
    test_rr_wrap();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
